// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame geometry and parity modes.
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

  localparam logic PARITY_EVEN     = 1'b0;
  localparam logic PARITY_ODD_MODE = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Push handshake, baud tick and serial status of the buffered UART transmitter.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
);

  logic                 tick;
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [ADDR_W:0]      fifo_count;
  logic                 overflow;
  logic                 busy;
  logic                 tx_done;
  logic                 tx;

  modport master (
    output tick, wr_en, wr_data,
    input  full, empty, fifo_count, overflow, busy, tx_done, tx
  );

  modport slave (
    input  tick, wr_en, wr_data,
    output full, empty, fifo_count, overflow, busy, tx_done, tx
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is presented combinationally on rd_data.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             push;
  logic             pop;

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 (optional parity) UART transmitter draining a FIFO back-to-back on the oversampled baud tick.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_ADDR_W = 4,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_fifo_if.slave   bus
);

  localparam int                CNT_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int                BIT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              PAR_INIT  = (PARITY_ODD != 0) ? PARITY_ODD_MODE : PARITY_EVEN;

  localparam logic [2:0] IDLE   = 3'(TX_IDLE);
  localparam logic [2:0] START  = 3'(TX_START);
  localparam logic [2:0] DATA   = 3'(TX_DATA);
  localparam logic [2:0] PARITY = 3'(TX_PARITY);
  localparam logic [2:0] STOP   = 3'(TX_STOP);

  logic [2:0]           state, state_n;
  logic [CNT_W-1:0]     tick_cnt, tick_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 tx_q, tx_n;
  logic                 tx_done_q, done_n;
  logic                 overflow_q;
  logic                 pop;
  logic                 bit_end;

  logic [DATA_BITS-1:0] head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FIFO_ADDR_W:0] fifo_count;

  sync_fifo #(
    .WIDTH  (DATA_BITS),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bit_end = bus.tick && (tick_cnt == TICK_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    pop        = 1'b0;
    done_n     = 1'b0;
    tx_n       = 1'b1;

    if (state != IDLE && bus.tick)
      tick_cnt_n = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (bus.tick && !fifo_empty) begin
          pop        = 1'b1;
          shift_n    = head;
          tick_cnt_n = '0;
          state_n    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
          else                     bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          done_n = 1'b1;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[bit_cnt_n];
      PARITY:  tx_n = (^shift_n) ^ PAR_INIT;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      tx_q       <= tx_n;
      tx_done_q  <= done_n;
      overflow_q <= bus.wr_en && fifo_full;
    end
  end

  assign bus.full       = fifo_full;
  assign bus.empty      = fifo_empty;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state != IDLE);
  assign bus.tx_done    = tx_done_q;
  assign bus.tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: 8N1 framing, back-to-back drain, overflow, parity and mid-frame reset.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int unsigned FRAME10 = 640;  // 10 bits * 16 ticks * 4 clk
  localparam int unsigned FRAME11 = 704;  // 11 bits * 16 ticks * 4 clk

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic [10:0] frame;  // bit i = i-th bit on the line, start bit first
  } vec_t;

  typedef struct {
    logic [9:0]  frame;
    int unsigned start;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tk  = 1'b0;
  bit          tick_en = 1'b0;
  int          phase = 0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  frame_t      rx_q[$];
  frame_t      mon_f;
  int unsigned done_q[$];
  int          done_cnt = 0;

  vec_t        t1_vec[1];
  vec_t        t2_vec[3];
  vec_t        par_vec[2];

  uart_tx_fifo_if #(.ADDR_W(4)) dbus ();
  uart_tx_fifo_if #(.ADDR_W(4)) pbus_o ();
  uart_tx_fifo_if #(.ADDR_W(4)) pbus_e ();

  uart_tx_fifo #(.FIFO_ADDR_W(4), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0))
    dut (.clk(clk), .rst(rst), .bus(dbus));
  uart_tx_fifo #(.FIFO_ADDR_W(4), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1))
    dut_po (.clk(clk), .rst(rst), .bus(pbus_o));
  uart_tx_fifo #(.FIFO_ADDR_W(4), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0))
    dut_pe (.clk(clk), .rst(rst), .bus(pbus_e));

  assign dbus.tick   = tk;
  assign pbus_o.tick = tk;
  assign pbus_e.tick = tk;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // One-clk tick every fourth clock while enabled.
  initial forever begin
    @(negedge clk);
    tk    = tick_en && (phase == 0);
    phase = (phase + 1) % 4;
  end

  // Line monitor for the default instance: samples each bit at its centre.
  initial forever begin
    @(negedge clk);
    if (!rst && dbus.tx === 1'b0) begin
      mon_f.start = cyc;
      repeat (32) @(negedge clk);
      mon_f.frame[0] = dbus.tx;
      for (int i = 1; i < 10; i++) begin
        repeat (64) @(negedge clk);
        mon_f.frame[i] = dbus.tx;
      end
      repeat (31) @(negedge clk);
      rx_q.push_back(mon_f);
    end
  end

  initial forever begin
    @(negedge clk);
    if (dbus.tx_done === 1'b1) begin
      done_cnt++;
      done_q.push_back(cyc);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, expected finish before 600us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] d);
    dbus.wr_en   = 1'b1;
    dbus.wr_data = d;
    @(negedge clk);
    dbus.wr_en   = 1'b0;
  endtask

  task automatic wait_fall(input string name, output int unsigned c0);
    bit found;
    found = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (dbus.tx === 1'b0) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check(name, 32'(found), 32'd1);
    c0 = cyc;
  endtask

  initial begin
    int unsigned c0;
    int unsigned prev;
    int          base_done;
    int          idle_bad;
    bit          found;
    logic [10:0] fo, fe;
    logic [31:0] cnt_q[$];
    logic [7:0]  d;

    t1_vec[0]  = '{name: "t1_0x55",     data: 8'h55, frame: 11'h2AA};
    t2_vec[0]  = '{name: "t2_0x41",     data: 8'h41, frame: 11'h282};
    t2_vec[1]  = '{name: "t2_0x42",     data: 8'h42, frame: 11'h284};
    t2_vec[2]  = '{name: "t2_0x43",     data: 8'h43, frame: 11'h286};
    par_vec[0] = '{name: "t4_odd_0x07", data: 8'h07, frame: 11'h40E};
    par_vec[1] = '{name: "t4_even_0x07",data: 8'h07, frame: 11'h60E};

    dbus.wr_en = 1'b0;   dbus.wr_data = '0;
    pbus_o.wr_en = 1'b0; pbus_o.wr_data = '0;
    pbus_e.wr_en = 1'b0; pbus_e.wr_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx",       32'(dbus.tx),       32'd1);
    check("rst_busy",     32'(dbus.busy),     32'd0);
    check("rst_tx_done",  32'(dbus.tx_done),  32'd0);
    check("rst_overflow", 32'(dbus.overflow), 32'd0);
    check("rst_empty",    32'(dbus.empty),    32'd1);
    check("rst_full",     32'(dbus.full),     32'd0);
    check("rst_count",    32'(dbus.fifo_count), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_tx",  32'(dbus.tx), 32'd1);

    // Test 1: single 0x55 frame
    tick_en = 1'b1;
    push(t1_vec[0].data);
    check("t1_count_after_push", 32'(dbus.fifo_count), 32'd1);
    for (int t = 0; t < 1000 && done_cnt < 1; t++) @(negedge clk);
    check("t1_done_seen", 32'(done_cnt), 32'd1);
    check("t1_busy_at_done",  32'(dbus.busy),  32'd0);
    check("t1_empty_at_done", 32'(dbus.empty), 32'd1);
    check("t1_frames", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() >= 1 && done_q.size() >= 1) begin
      check(t1_vec[0].name, 32'(rx_q[0].frame), 32'(t1_vec[0].frame));
      check("t1_frame_len", done_q[0] - rx_q[0].start, FRAME10);
    end
    repeat (100) @(negedge clk);
    check("t1_single_pulse", 32'(done_cnt), 32'd1);

    // Test 2: three queued bytes drain back-to-back
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    foreach (t2_vec[i]) push(t2_vec[i].data);
    check("t2_count_3", 32'(dbus.fifo_count), 32'd3);
    tick_en = 1'b1;
    prev = 3;
    for (int t = 0; t < 3000 && done_cnt < 4; t++) begin
      @(negedge clk);
      if (32'(dbus.fifo_count) != prev) begin
        prev = 32'(dbus.fifo_count);
        cnt_q.push_back(prev);
      end
    end
    check("t2_done_count", 32'(done_cnt), 32'd4);
    check("t2_count_steps", 32'(cnt_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2_count_step%0d", i),
            (i < cnt_q.size()) ? cnt_q[i] : 32'hFFFF_FFFF, 32'(2 - i));
    check("t2_frames", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (rx_q.size() > i + 1) begin
        check(t2_vec[i].name, 32'(rx_q[i+1].frame), 32'(t2_vec[i].frame));
        if (i > 0)
          check($sformatf("t2_gap%0d", i), rx_q[i+1].start - rx_q[i].start, FRAME10);
      end
    end

    // Test 3: fill with ticks held off, 17th push overflows
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    rx_q.delete();
    done_q.delete();
    base_done = done_cnt;
    for (int i = 0; i < 17; i++) begin
      dbus.wr_en   = 1'b1;
      dbus.wr_data = 8'(i);
      @(negedge clk);
      if (i == 15) begin
        check("t3_full_at_16",     32'(dbus.full),       32'd1);
        check("t3_count_at_16",    32'(dbus.fifo_count), 32'd16);
        check("t3_no_overflow_16", 32'(dbus.overflow),   32'd0);
      end
      if (i == 16) check("t3_overflow_pulse", 32'(dbus.overflow), 32'd1);
    end
    dbus.wr_en = 1'b0;
    @(negedge clk);
    check("t3_overflow_one_cycle", 32'(dbus.overflow),   32'd0);
    check("t3_count_still_16",     32'(dbus.fifo_count), 32'd16);

    // Test 6: push refused on the STOP->START pop cycle while full
    tick_en = 1'b1;
    wait_fall("t6_start_seen", c0);
    check("t6_count_after_first_pop", 32'(dbus.fifo_count), 32'd15);
    push(8'h11);
    check("t6_full_again", 32'(dbus.full), 32'd1);
    while (cyc < c0 + FRAME10 - 1) @(negedge clk);
    dbus.wr_en   = 1'b1;
    dbus.wr_data = 8'hEE;
    @(negedge clk);
    dbus.wr_en   = 1'b0;
    check("t6_overflow",     32'(dbus.overflow),   32'd1);
    check("t6_count_15",     32'(dbus.fifo_count), 32'd15);
    check("t6_done_aligned", 32'(dbus.tx_done),    32'd1);
    @(negedge clk);
    check("t6_overflow_clear", 32'(dbus.overflow), 32'd0);
    for (int t = 0; t < 12000 && rx_q.size() < 17; t++) @(negedge clk);
    repeat (700) @(negedge clk);
    check("t36_frames", 32'(rx_q.size()), 32'd17);
    for (int i = 0; i < 17; i++) begin
      d = (i < 16) ? 8'(i) : 8'h11;
      if (i < rx_q.size()) begin
        check($sformatf("t36_frame%0d", i), 32'(rx_q[i].frame), 32'({1'b1, d, 1'b0}));
        if (i > 0)
          check($sformatf("t36_gap%0d", i), rx_q[i].start - rx_q[i-1].start, FRAME10);
      end
    end
    check("t36_done_count", 32'(done_cnt - base_done), 32'd17);
    check("t36_empty", 32'(dbus.empty), 32'd1);
    check("t36_busy",  32'(dbus.busy),  32'd0);

    // Test 4: odd and even parity instances, 11-bit frames
    pbus_o.wr_en = 1'b1; pbus_o.wr_data = par_vec[0].data;
    pbus_e.wr_en = 1'b1; pbus_e.wr_data = par_vec[1].data;
    @(negedge clk);
    pbus_o.wr_en = 1'b0;
    pbus_e.wr_en = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (pbus_o.tx === 1'b0) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("t4_start_seen", 32'(found), 32'd1);
    c0 = cyc;
    repeat (32) @(negedge clk);
    fo[0] = pbus_o.tx;
    fe[0] = pbus_e.tx;
    for (int i = 1; i < 11; i++) begin
      repeat (64) @(negedge clk);
      fo[i] = pbus_o.tx;
      fe[i] = pbus_e.tx;
    end
    while (pbus_o.tx_done !== 1'b1 && cyc < c0 + 800) @(negedge clk);
    check(par_vec[0].name, 32'(fo), 32'(par_vec[0].frame));
    check(par_vec[1].name, 32'(fe), 32'(par_vec[1].frame));
    check("t4_frame_len", cyc - c0, FRAME11);
    check("t4_even_done", 32'(pbus_e.tx_done), 32'd1);

    // Test 5: asynchronous reset during data bit 3 of 0xA5
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    push(8'hA5);
    push(8'hB6);
    push(8'hC7);
    tick_en = 1'b1;
    wait_fall("t5_start_seen", c0);
    while (cyc < c0 + 288) @(negedge clk);
    check("t5_bit3_low", 32'(dbus.tx), 32'd0);
    base_done = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("t5_tx_async",  32'(dbus.tx),         32'd1);
    check("t5_busy",      32'(dbus.busy),       32'd0);
    check("t5_empty",     32'(dbus.empty),      32'd1);
    check("t5_count",     32'(dbus.fifo_count), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      if (dbus.tx !== 1'b1 || dbus.busy !== 1'b0) idle_bad++;
    end
    check("t5_idle_after_release", 32'(idle_bad), 32'd0);
    check("t5_no_tx_done", 32'(done_cnt - base_done), 32'd0);
    check("t5_still_empty", 32'(dbus.empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
